// File: rtl/multiplier_if.sv
// RV32M multiply opcode set and the exe_stage <-> multiplier operand/result bundle.
// The master side is the exe_stage sign logic; the slave side is the multiplier.
package multiplier_pkg;
  localparam logic [3:0] ALU_MUL    = 4'd10;
  localparam logic [3:0] ALU_MULH   = 4'd11;
  localparam logic [3:0] ALU_MULHSU = 4'd12;
  localparam logic [3:0] ALU_MULHU  = 4'd13;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
  endfunction
endpackage

interface multiplier_if #(parameter int XLEN = 32);
  logic [3:0]      id_alu_op_r;
  logic            mul_div_negative_w;
  logic [XLEN-1:0] mul_div_a_w;
  logic [XLEN-1:0] mul_div_b_w;
  logic [XLEN-1:0] mul_lo_w;
  logic [XLEN-1:0] mul_hi_w;
  logic            ex_stall_mul_w;

  modport master (
    output id_alu_op_r, mul_div_negative_w, mul_div_a_w, mul_div_b_w,
    input  mul_lo_w, mul_hi_w, ex_stall_mul_w
  );

  modport slave (
    input  id_alu_op_r, mul_div_negative_w, mul_div_a_w, mul_div_b_w,
    output mul_lo_w, mul_hi_w, ex_stall_mul_w
  );
endinterface

// File: rtl/multiplier.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU on unsigned magnitudes.
// Define MUL_RADIX4_EN to retire two multiplier bits per cycle (XLEN/2+1 stall cycles).
module multiplier
  import multiplier_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  multiplier_if.slave       bus
);

  localparam int CNT_W = $clog2(XLEN);
`ifdef MUL_RADIX4_EN
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN/2 - 1);
`else
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_READY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN:0]     acc_q, acc_d;
  logic [XLEN-1:0]   plier_q, plier_d;
  logic [XLEN-1:0]   cand_q, cand_d;

  logic              req;
  logic              ready;
  logic [XLEN:0]     step_acc;
  logic [XLEN-1:0]   step_plier;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] res;

  assign req   = is_mul_op(bus.id_alu_op_r);
  assign ready = (state_q == S_READY);

  // One iteration: add the selected partial product, then shift {acc, plier} right.
`ifdef MUL_RADIX4_EN
  logic [XLEN+1:0] pp, sum;
  always_comb begin
    pp = '0;
    case (plier_q[1:0])
      2'd1:    pp = {2'b00, cand_q};
      2'd2:    pp = {1'b0, cand_q, 1'b0};
      2'd3:    pp = {2'b00, cand_q} + {1'b0, cand_q, 1'b0};
      default: pp = '0;
    endcase
    sum        = {1'b0, acc_q} + pp;
    step_acc   = {1'b0, sum[XLEN+1:2]};
    step_plier = {sum[1:0], plier_q[XLEN-1:2]};
  end
`else
  logic [XLEN:0] sum;
  always_comb begin
    sum        = acc_q + (plier_q[0] ? {1'b0, cand_q} : {(XLEN+1){1'b0}});
    step_acc   = {1'b0, sum[XLEN:1]};
    step_plier = {sum[0], plier_q[XLEN-1:1]};
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    plier_d = plier_q;
    cand_d  = cand_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_BUSY;
          cnt_d   = CNT_LOAD;
          acc_d   = '0;
          plier_d = bus.mul_div_a_w;
          cand_d  = bus.mul_div_b_w;
        end
      end
      S_BUSY: begin
        // Runs to completion even if the request is flushed.
        acc_d   = step_acc;
        plier_d = step_plier;
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_READY;
      end
      // The request seen here is the same instruction completing; never restart.
      S_READY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      plier_q <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      plier_q <= plier_d;
      cand_q  <= cand_d;
    end
  end

  assign prod = {acc_q[XLEN-1:0], plier_q};
  assign res  = bus.mul_div_negative_w ? (~prod + 1'b1) : prod;

  assign bus.mul_lo_w       = res[XLEN-1:0];
  assign bus.mul_hi_w       = res[2*XLEN-1:XLEN];
  assign bus.ex_stall_mul_w = req && !ready;

endmodule

// File: tb/tb_multiplier.sv
// Directed vector bench for the iterative multiplier: latency, results, flush, reset abort.
module tb_multiplier;
  import multiplier_pkg::*;

  localparam int XLEN = 32;
`ifdef MUL_RADIX4_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 33;
`endif
  localparam logic [3:0] ALU_NOP = 4'd0;

  typedef struct {
    logic [3:0]  op;
    logic        neg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[10];

  multiplier_if #(.XLEN(XLEN)) bus ();
  multiplier #(.XLEN(XLEN)) u_dut (.clk_i(clk), .reset_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic neg, input logic [31:0] a, input logic [31:0] b);
    bus.id_alu_op_r        = op;
    bus.mul_div_negative_w = neg;
    bus.mul_div_a_w        = a;
    bus.mul_div_b_w        = b;
  endtask

  // Issues a request at a negedge, holds it until stall drops, samples the ready cycle.
  task automatic run_op(input vec_t v, output int stalls, output logic [31:0] lo, output logic [31:0] hi);
    @(negedge clk);
    drive(v.op, v.neg, v.a, v.b);
    #1;
    stalls = 0;
    while (bus.ex_stall_mul_w === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    lo = bus.mul_lo_w;
    hi = bus.mul_hi_w;
    drive(ALU_NOP, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int          st;
    logic [31:0] lo, hi;

    vecs[0] = '{ALU_MUL,    1'b0, 32'd7,        32'd6,        32'd42,       32'h0};
    vecs[1] = '{ALU_MULHU,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{ALU_MULH,   1'b1, 32'd3,        32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF};
    vecs[3] = '{ALU_MUL,    1'b0, 32'd2,        32'd3,        32'd6,        32'h0};
    vecs[4] = '{ALU_MUL,    1'b0, 32'd4,        32'd5,        32'd20,       32'h0};
    vecs[5] = '{ALU_MULHSU, 1'b0, 32'd0,        32'h12345678, 32'h0,        32'h0};
    vecs[6] = '{ALU_MUL,    1'b0, 32'h80000000, 32'd2,        32'h0,        32'h1};
    vecs[7] = '{ALU_MULHU,  1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 32'h0};
    vecs[8] = '{ALU_MULHSU, 1'b1, 32'd1,        32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[9] = '{ALU_MULH,   1'b0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h1};

    drive(ALU_NOP, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_stall", {31'h0, bus.ex_stall_mul_w}, 32'h0);
    check("reset_lo", bus.mul_lo_w, 32'h0);
    check("reset_hi", bus.mul_hi_w, 32'h0);
    rst_n = 1'b1;

    // Consecutive entries start the cycle after the previous ready: back-to-back coverage.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], st, lo, hi);
      check($sformatf("v%0d_stall_cycles", i), st, LAT);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
    end

    // Operands clobbered after acceptance, request flushed at cycle 10, re-raised to probe ready.
    repeat (2) @(negedge clk);
    drive(ALU_MUL, 1'b0, 32'h10000, 32'h10000);
    @(negedge clk);
    drive(ALU_MUL, 1'b0, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    #1;
    check("flush_stall_c10", {31'h0, bus.ex_stall_mul_w}, 32'h1);
    drive(ALU_NOP, 1'b0, 32'h0, 32'h0);
    #1;
    check("flush_stall_dropped", {31'h0, bus.ex_stall_mul_w}, 32'h0);
    repeat (LAT - 11) @(negedge clk);
    drive(ALU_MUL, 1'b0, 32'h0, 32'h0);
    #1;
    check("flush_busy_before_ready", {31'h0, bus.ex_stall_mul_w}, 32'h1);
    @(negedge clk);
    #1;
    check("flush_ready_stall", {31'h0, bus.ex_stall_mul_w}, 32'h0);
    check("flush_lo", bus.mul_lo_w, 32'h0);
    check("flush_hi", bus.mul_hi_w, 32'h1);
    drive(ALU_NOP, 1'b0, 32'h0, 32'h0);

    // Asynchronous reset mid-operation aborts it.
    repeat (2) @(negedge clk);
    drive(ALU_MUL, 1'b0, 32'd7, 32'd6);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive(ALU_NOP, 1'b0, 32'h0, 32'h0);
    #1;
    check("rst_mid_stall", {31'h0, bus.ex_stall_mul_w}, 32'h0);
    check("rst_mid_lo", bus.mul_lo_w, 32'h0);
    check("rst_mid_hi", bus.mul_hi_w, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vecs[0], st, lo, hi);
    check("post_rst_stall_cycles", st, LAT);
    check("post_rst_lo", lo, 32'd42);
    check("post_rst_hi", hi, 32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Iterative shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU ops.
- Sits in exe_stage beside the divider and shares the same operand path: unsigned magnitudes plus a result-negate flag, produced by the exe_stage sign logic.
- Stalls the pipeline while it works, then presents a full 64-bit product for one cycle.

Parameters:
- XLEN, 32, operand width; the product is 2*XLEN.

Ports:
- clk_i  input  1  clock, rising edge.
- reset_ni  input  1  asynchronous, active-low reset.
- id_alu_op_r  input  4  ALU opcode; a request is any of ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU (from defines.sv).
- mul_div_negative_w  input  1  negate the final product; must be valid in the ready cycle.
- mul_div_a_w  input  XLEN  multiplier magnitude, unsigned.
- mul_div_b_w  input  XLEN  multiplicand magnitude, unsigned.
- mul_lo_w  output  XLEN  bits [XLEN-1:0] of the (possibly negated) product.
- mul_hi_w  output  XLEN  bits [2*XLEN-1:XLEN] of the (possibly negated) product.
- ex_stall_mul_w  output  1  stall request to the pipeline.

Behaviour:
- Reset is asynchronous and active-low: clk_i is the only clock; reset_ni low clears all state immediately, independent of clk_i.
- Registers and reset values:
  - mul_busy_r = 0, mul_ready_r = 0, mul_count_r = 0.
  - mul_acc_r (XLEN+1 bits) = 0, mul_plier_r = 0, mul_cand_r = 0.
  - With negative = 0 after reset, mul_lo_w = mul_hi_w = 0.
- Control is three implicit states, priority busy > ready > idle:
  - IDLE, request present: mul_count_r = XLEN-1, mul_busy_r = 1, mul_plier_r = a, mul_cand_r = b (latched; inputs need not stay stable afterwards), mul_acc_r = 0.
  - BUSY, each cycle:
    - sum = mul_acc_r + (mul_plier_r[0] ? mul_cand_r : 0), XLEN+1 bits, no overflow.
    - {mul_acc_r, mul_plier_r} <= {1'b0, sum, mul_plier_r[XLEN-1:1]} truncated to 2*XLEN+1 bits, i.e. a logical right shift of {sum, plier}.
    - mul_count_r decrements. When mul_count_r == 0 on that cycle: busy clears and ready sets.
  - READY: lasts exactly one cycle; ready clears. A request present in this cycle is NOT restarted; it is the same instruction completing.
- Product is prod = {mul_acc_r[XLEN-1:0], mul_plier_r}. The outputs are mul_negative_w ? -prod : prod, in 2*XLEN-bit two's complement. They are combinational and valid whenever ready = 1.
- Stall: ex_stall_mul_w = request && !mul_ready_r.
- Latency: request in idle cycle N → stall high for cycles N..N+XLEN (XLEN+1 cycles) → ready and stall low in cycle N+XLEN+1.
- Boundary conditions:
  - Request dropped mid-BUSY (flush): the iteration still runs to completion and ready still pulses; the next request is accepted only after returning to idle.
  - Back-to-back requests: a second MUL in the cycle after ready is accepted normally.
  - Operand 0 takes full latency (no early exit).
  - a = b = 2^XLEN-1 gives 0xFFFFFFFE_00000001 with no carry loss.
  - Reset asserted mid-BUSY aborts the operation; no ready pulse follows.
- The multiplier and divider may be requested on exclusive opcodes only; there is no arbitration in this block.

Optional Feature:
- MUL_RADIX4_EN defined: two multiplier bits are retired per cycle.
  - Each cycle adds (plier[1:0] × cand), an (XLEN+2)-bit add, then shifts by 2.
  - mul_count_r loads XLEN/2-1; stall spans XLEN/2+1 cycles (17 for XLEN=32).
- Undefined: radix-2 as described above (33 stall cycles).
- Results are identical in both modes.

Test Plan:
- Reset: reset_ni low asynchronously mid-BUSY → stall drops with the request removed, mul_lo_w = mul_hi_w = 0; next request gives full latency.
- ALU_MUL, a = 7, b = 6, negative = 0 → stall for 33 cycles, then ready cycle with mul_lo_w = 42, mul_hi_w = 0; stall low that cycle.
- ALU_MULHU, a = b = 0xFFFFFFFF → mul_hi_w = 0xFFFFFFFE, mul_lo_w = 0x00000001.
- ALU_MULH, a = 3, b = 5, negative = 1 → mul_hi_w = 0xFFFFFFFF, mul_lo_w = 0xFFFFFFF1 (-15).
- Operands changed to 0 on the cycle after acceptance; a = 0x10000, b = 0x10000 → mul_hi_w = 0x1, mul_lo_w = 0 (latched values used). Request dropped at cycle 10 → ready still pulses at cycle 33.
- Back-to-back: MUL 2×3 then MUL 4×5 with the second request the cycle after ready → results 6 then 20, each with 33 stall cycles; with MUL_RADIX4_EN, same results with 17 stall cycles each.
